result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Downstream stage of the byte-pair stimulus BFM and the Add DUT.
- Captures one 8-bit adder result per qualified cycle, aligned to the DUT's output latency.
- Packs NUM results into one wide word and hands it to the transaction layer with a valid/ready handshake. This is the readback mirror of the wide stimulus payload.

Parameters:
- NUM, 100, number of results per transaction
- DATA_W, 8, width of one result
- RES_WIDTH, NUM*DATA_W (800), width of the packed result word
- ALIGN_LAT, 1, cycles between the upstream issue strobe and the matching valid result; range 0..4

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  arm a new collection (pulse)
- in_valid  in  1  upstream issue strobe, high on the cycle an A/B pair is driven
- in_data  in  DATA_W  DUT result (res_o)
- out_data  out  RES_WIDTH  packed results
- out_valid  out  1  packed word complete and stable
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in COLLECT
- count  out  $clog2(NUM+1)  results captured so far
- dropped  out  1  sticky: a qualified result arrived outside COLLECT

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - out_data, out_valid, busy, count and dropped all go to 0.
  - The alignment pipe is cleared.
- Reset mid-operation discards the partial word. No out_valid follows.
- Alignment:
  - cap_v is in_valid delayed by ALIGN_LAT registers; ALIGN_LAT=0 means cap_v = in_valid.
  - in_data is sampled when cap_v is high. It is not delayed.
- State IDLE:
  - busy=0, out_valid=0.
  - start → COLLECT next edge; count ← 0, dropped ← 0, out_data ← 0.
- State COLLECT:
  - busy=1.
  - On cap_v, in_data is written to slot count, bits [count*DATA_W +: DATA_W], and count increments. The first result sits in the LSBs, matching the LSB-first stimulus unpacking.
  - On the capture that fills slot NUM-1: count ← NUM, state → HOLD, and out_valid rises on that same edge. out_valid is therefore visible the cycle after the last capture.
  - start during COLLECT is ignored.
- State HOLD:
  - out_valid=1. out_data and count stay stable until the handshake.
  - Handshake when out_valid && out_ready:
    - With start low, go to IDLE; out_valid ← 0 and count ← 0.
    - With start high in the same cycle, go directly to COLLECT; count ← 0, out_data ← 0, dropped ← 0.
  - start without out_ready is ignored.
- Drops:
  - cap_v while in IDLE or HOLD sets dropped. Data is discarded and no slot is written.
  - dropped stays set until the next accepted start or reset.
- Widths:
  - count saturates at NUM; it never wraps.
  - Slot indexing never exceeds NUM-1.
- Throughput: one capture per cycle sustained. Back-to-back cap_v for NUM cycles fills the word in NUM cycles.
- out_valid is never deasserted without a handshake or reset.

Decomposition:
- Shared package tb_pkg:
  - state typedef enum {IDLE, COLLECT, HOLD}.
  - Default DATA_W.
  - Helper localparam for count width.
- One sub-module valid_delay_line (parameter LAT) implementing the ALIGN_LAT flop chain with async reset. When LAT=0 it passes the input through.

Test Plan (NUM=4, ALIGN_LAT=1 unless noted):
1. Basic fill:
   - Stimulus: reset, start, then in_valid for 4 cycles with in_data lagging one cycle: 0x03, 0x10, 0xFF, 0x7E.
   - Required: out_valid rises one cycle after the 4th capture; out_data = 0x7EFF1003; count = 4.
2. Hold and handshake:
   - Stimulus: keep out_ready low for 5 cycles, then raise it.
   - Required: out_data stays stable; out_valid drops the cycle after the handshake; state IDLE, count 0.
3. Gapped input:
   - Stimulus: in_valid pattern 1,0,0,1,1,0,1 with results 0x01, 0x02, 0x03, 0x04.
   - Required: out_data = 0x04030201, no drops.
4. Drop and sticky flag:
   - Stimulus: cap_v in IDLE with in_data 0xAA, then start and a normal fill.
   - Required: dropped=1 after the stray capture, cleared by start; 0xAA absent from out_data.
5. Chained start:
   - Stimulus: start asserted in the same cycle as the HOLD handshake.
   - Required: state goes directly to COLLECT, busy=1 next cycle; second word collects correctly.
6. Reset mid-collect:
   - Stimulus: assert reset asynchronously after 2 captures.
   - Required: all outputs 0 immediately; no out_valid until a new start plus 4 captures.
   - Repeat scenario 1 with ALIGN_LAT=0 and ALIGN_LAT=2; the same word is required when in_data timing is shifted to match.

Source files
------------

// File: rtl/result_packer_pkg.sv
// result_packer_pkg: shared types and sizing helpers for the result packer
package result_packer_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM = 100;
  localparam int DEF_CW = $clog2(DEF_NUM + 1);
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/result_packer_valid_delay_line.sv
// valid_delay_line: delays the issue strobe so it lines up with the adder result
module valid_delay_line #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  if (LAT == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [LAT-1:0] sr;
    // shift the strobe through LAT flops, oldest at the MSB
    always_ff @(posedge clk or posedge reset)
      if (reset) sr <= '0;
      else sr <= LAT'({sr, d});
    assign q = sr[LAT-1];
  end
endmodule

// File: rtl/result_packer.sv
// result_packer: packs NUM aligned adder results LSB-first into one handshaked word
module result_packer
  import result_packer_pkg::*;
#(
  parameter int NUM = DEF_NUM,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_WIDTH = NUM * DATA_W,
  parameter int ALIGN_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic [RES_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [cnt_w(NUM)-1:0]   count,
  output logic                    dropped
);
  localparam int CW = cnt_w(NUM);
  state_t state, state_nx;
  logic cap_v, last, arm;
  valid_delay_line #(.LAT(ALIGN_LAT)) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    (in_valid),
    .q    (cap_v)
  );
  assign last = cap_v && count == CW'(NUM - 1);
  assign arm = start && (state == IDLE || (state == HOLD && out_ready));
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: start arms from IDLE or from a completing handshake
  always_comb
    state_nx = state == IDLE    ? (start ? COLLECT : IDLE) :
               state == COLLECT ? (last ? HOLD : COLLECT) :
               out_ready        ? (start ? COLLECT : IDLE) : HOLD;
  // status outputs decoded from state
  always_comb begin
    busy = state == COLLECT;
    out_valid = state == HOLD;
  end
  // capture into the next free slot; stray captures only raise the sticky flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_data <= '0;
      count <= '0;
      dropped <= 1'b0;
    end else begin
      if (arm) begin
        out_data <= '0;
        count <= '0;
      end else if (state == COLLECT && cap_v) begin
        out_data[count*DATA_W +: DATA_W] <= in_data;
        count <= count + CW'(1);
      end else if (state == HOLD && out_ready) begin
        count <= '0;
      end
      if (cap_v && state != COLLECT) dropped <= 1'b1;
      else if (arm) dropped <= 1'b0;
    end
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: scoreboard bench driving three packers with alignment latencies 0, 1 and 2
module tb_result_packer;
  localparam int NUM = 4;
  localparam int DW = 8;
  localparam int RW = NUM * DW;
  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [DW-1:0] val, vh1, vh2;
  logic [RW-1:0] od [3];
  logic ov [3], bz [3], dr [3];
  logic [2:0] cnt [3];
  logic [RW-1:0] exp_w [$];
  int rd [3];
  logic pv [3];
  logic [RW-1:0] pod [3];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // model of the adder output pipe: result appears L cycles after issue
  always @(posedge clk) begin
    vh1 <= val;
    vh2 <= vh1;
  end

  result_packer #(.NUM(NUM), .DATA_W(DW), .ALIGN_LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(val),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]),
    .count(cnt[0]), .dropped(dr[0]));
  result_packer #(.NUM(NUM), .DATA_W(DW), .ALIGN_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(vh1),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]),
    .count(cnt[1]), .dropped(dr[1]));
  result_packer #(.NUM(NUM), .DATA_W(DW), .ALIGN_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(vh2),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]),
    .count(cnt[2]), .dropped(dr[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [RW-1:0] pack(input logic [DW-1:0] v [NUM]);
    logic [RW-1:0] w = '0;
    for (int k = 0; k < NUM; k++) w |= RW'(v[k]) << (DW * k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("busy_after_start[%0d]", i), bz[i], 1);
  endtask

  task automatic fill(input logic [DW-1:0] v [NUM], input int g [NUM]);
    exp_w.push_back(pack(v));
    for (int k = 0; k < NUM; k++) begin
      repeat (g[k]) begin
        in_valid = 1'b0;
        val = DW'($urandom);
        tick();
      end
      in_valid = 1'b1;
      val = v[k];
      tick();
    end
    in_valid = 1'b0;
    val = DW'($urandom);
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!(ov[0] && ov[1] && ov[2]) && n < 10) begin
      tick();
      n++;
    end
    chk("hold_timeout", n < 10, 1);
  endtask

  task automatic handshake(input int dly, input logic chain);
    repeat (dly) tick();
    out_ready = 1'b1;
    start = chain;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ov_after_hs[%0d]", i), ov[i], 0);
      chk($sformatf("busy_after_hs[%0d]", i), bz[i], chain);
      chk($sformatf("cnt_after_hs[%0d]", i), cnt[i], 0);
    end
  endtask

  // monitor: on every accepted word compare against the scoreboard; held words must not move
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) pv[i] = 1'b0;
      else begin
        if (ov[i]) begin
          if (pv[i]) begin
            chk($sformatf("hold_stable[%0d]", i), od[i], pod[i]);
            chk($sformatf("hold_count[%0d]", i), cnt[i], NUM);
          end
          if (out_ready) begin
            if (rd[i] < exp_w.size()) chk($sformatf("word[%0d]#%0d", i, rd[i]), od[i], exp_w[rd[i]]);
            else chk($sformatf("spurious_word[%0d]", i), rd[i], exp_w.size());
            rd[i]++;
          end
        end
        pv[i] = ov[i] && !out_ready;
        pod[i] = od[i];
      end
    end
  end

  initial begin
    logic [DW-1:0] v [NUM];
    int g [NUM];
    logic chain;
    for (int i = 0; i < 3; i++) rd[i] = 0;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    val = '0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_od[%0d]", i), od[i], 0);
      chk($sformatf("rst_ov[%0d]", i), ov[i], 0);
      chk($sformatf("rst_busy[%0d]", i), bz[i], 0);
      chk($sformatf("rst_cnt[%0d]", i), cnt[i], 0);
      chk($sformatf("rst_drop[%0d]", i), dr[i], 0);
    end
    reset = 1'b0;
    tick();
    // basic fill with per-latency out_valid timing
    pulse_start();
    v = '{8'h03, 8'h10, 8'hFF, 8'h7E};
    g = '{0, 0, 0, 0};
    fill(v, g);
    chk("lat0_ov_rise", ov[0], 1);
    chk("lat1_ov_early", ov[1], 0);
    tick();
    chk("lat1_ov_rise", ov[1], 1);
    chk("lat1_word", od[1], 32'h7EFF1003);
    chk("lat1_count", cnt[1], NUM);
    chk("lat2_ov_early", ov[2], 0);
    tick();
    chk("lat2_ov_rise", ov[2], 1);
    handshake(5, 1'b0);
    // gapped input 1,0,0,1,1,0,1
    pulse_start();
    v = '{8'h01, 8'h02, 8'h03, 8'h04};
    g = '{0, 2, 0, 1};
    fill(v, g);
    wait_hold();
    for (int i = 0; i < 3; i++) chk($sformatf("gap_nodrop[%0d]", i), dr[i], 0);
    handshake(0, 1'b0);
    // stray capture in IDLE, then cleared by start
    in_valid = 1'b1;
    val = 8'hAA;
    tick();
    in_valid = 1'b0;
    val = 8'h00;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("drop_set[%0d]", i), dr[i], 1);
    pulse_start();
    for (int i = 0; i < 3; i++) chk($sformatf("drop_clr[%0d]", i), dr[i], 0);
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    g = '{1, 0, 0, 0};
    fill(v, g);
    wait_hold();
    handshake(2, 1'b1);
    // chained start straight into a second word
    for (int k = 0; k < NUM; k++) begin
      v[k] = DW'($urandom);
      g[k] = 0;
    end
    fill(v, g);
    wait_hold();
    handshake(1, 1'b0);
    // asynchronous reset after two captures discards the partial word
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      val = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_od[%0d]", i), od[i], 0);
      chk($sformatf("arst_ov[%0d]", i), ov[i], 0);
      chk($sformatf("arst_busy[%0d]", i), bz[i], 0);
      chk($sformatf("arst_cnt[%0d]", i), cnt[i], 0);
    end
    tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      for (int i = 0; i < 3; i++) chk($sformatf("arst_no_ov[%0d]", i), ov[i], 0);
    end
    // randomized transactions with random gaps, ready delays and chaining
    chain = 1'b0;
    repeat (10) begin
      if (!chain) pulse_start();
      for (int k = 0; k < NUM; k++) begin
        v[k] = DW'($urandom);
        g[k] = $urandom_range(0, 2);
      end
      fill(v, g);
      wait_hold();
      chain = 1'($urandom_range(0, 1));
      handshake($urandom_range(0, 3), chain);
    end
    if (chain) begin
      for (int k = 0; k < NUM; k++) begin
        v[k] = DW'($urandom);
        g[k] = 0;
      end
      fill(v, g);
      wait_hold();
      handshake(0, 1'b0);
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("words_seen[%0d]", i), rd[i], exp_w.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
